// File: rtl/piso_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : piso_ctrl_pkg
// Description : Shared definitions for the PISO stream controller.
//               - state_t : controller state encoding (IDLE / DRAIN)
//               - clog2   : ceiling log2, used to size the slice counter
// Revision    : 1.0  initial release
// ============================================================================
package piso_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,   // nothing loaded
        DRAIN = 1'b1    // slices pending on the output stream
    } state_t;

    // Ceiling log2. clog2(1) = 0, so callers clamp the result to at least 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : piso_ctrl_pkg
`default_nettype wire

// File: rtl/piso.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : piso
// Description : Parallel-in / serial-out register. LOAD captures a wide word,
//               SHIFT moves it down by one narrow slice. LOAD wins over SHIFT.
//               DATA_OUT is always the low slice of the register.
// Ports       : CLK, RESET (sync, active-high), LOAD, SHIFT,
//               DATA_IN [DATA_IN_WIDTH], DATA_OUT [DATA_OUT_WIDTH]
// Revision    : 1.0  initial release
// ============================================================================
module piso
    import piso_ctrl_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      LOAD,
    input  logic                      SHIFT,
    input  logic [DATA_IN_WIDTH-1:0]  DATA_IN,
    output logic [DATA_OUT_WIDTH-1:0] DATA_OUT
);

    logic [DATA_IN_WIDTH-1:0] r_shreg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_shreg <= '0;
        end else if (LOAD) begin
            r_shreg <= DATA_IN;
        end else if (SHIFT) begin
            // Logical shift fills the vacated top slice with zeros.
            r_shreg <= r_shreg >> DATA_OUT_WIDTH;
        end
    end

    assign DATA_OUT = r_shreg[DATA_OUT_WIDTH-1:0];

endmodule : piso
`default_nettype wire

// File: rtl/piso_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : piso_stream_ctrl
// Description : Valid/ready sequencer around a piso. Takes one wide word and
//               emits DATA_IN_WIDTH/DATA_OUT_WIDTH narrow words, LSB slice
//               first, sustaining one output word per cycle across wide-word
//               boundaries.
// Ports       : CLK, RESET (sync, active-high)
//               IN_VALID / IN_READY / DATA_IN [DATA_IN_WIDTH]     wide input
//               OUT_VALID / OUT_READY / DATA_OUT [DATA_OUT_WIDTH]
//               OUT_LAST (final slice of the wide word)          narrow output
//               BUSY (a wide word is loaded and not fully drained)
// Revision    : 1.0  initial release
// ============================================================================
module piso_stream_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [DATA_IN_WIDTH-1:0]  DATA_IN,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [DATA_OUT_WIDTH-1:0] DATA_OUT,
    output logic                      OUT_LAST,
    output logic                      BUSY
);

    localparam int unsigned c_num_shifts = DATA_IN_WIDTH / DATA_OUT_WIDTH;
    localparam int unsigned c_idx_w      = (clog2(c_num_shifts) > 0) ? clog2(c_num_shifts) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_shifts - 1);

    generate
        if ((DATA_IN_WIDTH % DATA_OUT_WIDTH) != 0) begin : g_bad_width
            $error("piso_stream_ctrl: DATA_IN_WIDTH must be a multiple of DATA_OUT_WIDTH");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic               w_at_last;
    logic               w_in_fire;
    logic               w_out_fire;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_at_last   = (r_state == DRAIN) && (r_idx == c_last_idx);
        OUT_VALID   = (r_state == DRAIN);
        BUSY        = (r_state == DRAIN);
        OUT_LAST    = w_at_last;
        // OUT_READY feeds IN_READY combinationally so the next word can be
        // loaded on the same edge that retires the last slice (no bubble).
        IN_READY    = (r_state == IDLE) || (OUT_READY && w_at_last);
        w_in_fire   = IN_VALID && IN_READY;
        w_out_fire  = OUT_VALID && OUT_READY;

        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = DRAIN;
                    w_idx_nxt   = '0;
                end
            end
            DRAIN: begin
                if (w_out_fire) begin
                    if (!w_at_last) begin
                        w_idx_nxt = r_idx + c_idx_w'(1);
                    end else if (w_in_fire) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // A load on the last out_fire replaces the data; the piso's LOAD priority
    // guarantees no stray shift, and SHIFT is also masked on the last slice.
    piso #(
        .DATA_IN_WIDTH  (DATA_IN_WIDTH),
        .DATA_OUT_WIDTH (DATA_OUT_WIDTH)
    ) u_piso (
        .CLK      (CLK),
        .RESET    (RESET),
        .LOAD     (w_in_fire),
        .SHIFT    (w_out_fire && !w_at_last),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT)
    );

endmodule : piso_stream_ctrl
`default_nettype wire

// File: tb/tb_piso_stream_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_piso_stream_ctrl
// Description : Directed self-checking bench. DUT A is 64->16 (four slices),
//               DUT B is 16->16 (single slice). Inputs change on the falling
//               edge; outputs are checked 1ns later, well away from posedge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_piso_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [63:0] a_data_in  = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [15:0] a_data_out;
    logic        a_out_last;
    logic        a_busy;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_data_in  = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [15:0] b_data_out;
    logic        b_out_last;
    logic        b_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_stream_ctrl #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) u_dut_a (
        .CLK(clk), .RESET(rst),
        .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .DATA_IN(a_data_in),
        .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .DATA_OUT(a_data_out),
        .OUT_LAST(a_out_last), .BUSY(a_busy)
    );

    piso_stream_ctrl #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) u_dut_b (
        .CLK(clk), .RESET(rst),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .DATA_IN(b_data_in),
        .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .DATA_OUT(b_data_out),
        .OUT_LAST(b_out_last), .BUSY(b_busy)
    );

    // Advance to the next falling edge (inputs are then applied by the caller).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        next_cycle();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_last !== 1'b0 ||
            a_busy !== 1'b0 || a_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_a: rdy=%b vld=%b last=%b busy=%b dout=%h, want 1 0 0 0 0000",
                     a_in_ready, a_out_valid, a_out_last, a_busy, a_data_out);
        end
        n_cmp++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_out_last !== 1'b0 ||
            b_busy !== 1'b0 || b_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_b: rdy=%b vld=%b last=%b busy=%b dout=%h, want 1 0 0 0 0000",
                     b_in_ready, b_out_valid, b_out_last, b_busy, b_data_out);
        end
    endtask

    task automatic test_single_word();
        logic [15:0] exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        a_in_valid  = 1'b1;
        a_data_in   = 64'h4444_3333_2222_1111;
        a_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: in_ready=%b want 1", a_in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            a_in_valid = 1'b0;
            #1;
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_data_out !== exp[k] ||
                a_out_last !== (k == 3) || a_in_ready !== (k == 3) || a_busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_slice%0d: vld=%b dout=%h last=%b rdy=%b busy=%b, want 1 %h %b %b 1",
                         k, a_out_valid, a_data_out, a_out_last, a_in_ready, a_busy,
                         exp[k], (k == 3), (k == 3));
            end
        end
        next_cycle();
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_idle: vld=%b busy=%b rdy=%b, want 0 0 1",
                     a_out_valid, a_busy, a_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [8] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                                 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        a_in_valid  = 1'b1;
        a_data_in   = 64'hDDDD_CCCC_BBBB_AAAA;
        a_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept0: in_ready=%b want 1", a_in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k < 4) begin
                a_in_valid = 1'b1;
                a_data_in  = 64'h8888_7777_6666_5555;
            end else begin
                a_in_valid = 1'b0;
                a_data_in  = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            #1;
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_data_out !== exp[k] ||
                a_out_last !== (k == 3 || k == 7) ||
                a_in_ready !== (k == 3 || k == 7)) begin
                n_err++;
                $display("FAIL b2b_out%0d: vld=%b dout=%h last=%b rdy=%b, want 1 %h %b %b",
                         k, a_out_valid, a_data_out, a_out_last, a_in_ready,
                         exp[k], (k == 3 || k == 7), (k == 3 || k == 7));
            end
        end
        next_cycle();
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: vld=%b busy=%b, want 0 0", a_out_valid, a_busy);
        end
    endtask

    task automatic test_backpressure();
        a_in_valid  = 1'b1;
        a_data_in   = 64'h4444_3333_2222_1111;
        a_out_ready = 1'b1;
        next_cycle();
        a_in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_data_out !== 16'h1111 || a_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first: dout=%h vld=%b, want 1111 1", a_data_out, a_out_valid);
        end
        // Stall on 0x2222 while offering a word that must not be taken.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            a_out_ready = 1'b0;
            a_in_valid  = 1'b1;
            a_data_in   = 64'hEEEE_EEEE_EEEE_EEEE;
            #1;
            n_cmp++;
            if (a_data_out !== 16'h2222 || a_out_valid !== 1'b1 ||
                a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall%0d: dout=%h vld=%b last=%b rdy=%b, want 2222 1 0 0",
                         k, a_data_out, a_out_valid, a_out_last, a_in_ready);
            end
        end
        for (int k = 0; k < 3; k++) begin
            logic [15:0] exp;
            exp = 16'h2222 + 16'(k) * 16'h1111;
            next_cycle();
            a_out_ready = 1'b1;
            a_in_valid  = 1'b0;
            #1;
            n_cmp++;
            if (a_data_out !== exp || a_out_valid !== 1'b1 || a_out_last !== (k == 2)) begin
                n_err++;
                $display("FAIL bp_resume%0d: dout=%h vld=%b last=%b, want %h 1 %b",
                         k, a_data_out, a_out_valid, a_out_last, exp, (k == 2));
            end
        end
        next_cycle();
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: vld=%b busy=%b, want 0 0", a_out_valid, a_busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        a_in_valid  = 1'b1;
        a_data_in   = 64'h4444_3333_2222_1111;
        a_out_ready = 1'b1;
        next_cycle();           // 0x1111 on output, consumed
        a_in_valid = 1'b0;
        next_cycle();           // 0x2222 on output, consumed
        next_cycle();           // 0x3333 on output: reset wins over out_fire
        rst        = 1'b1;
        a_in_valid = 1'b1;
        a_data_in  = 64'h9999_9999_9999_9999;
        next_cycle();
        rst        = 1'b0;
        a_in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_data_out !== 16'h0000 ||
            a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid: vld=%b dout=%h busy=%b rdy=%b, want 0 0000 0 1",
                     a_out_valid, a_data_out, a_busy, a_in_ready);
        end
        a_in_valid = 1'b1;
        a_data_in  = 64'h0DDD_0CCC_0BBB_0AAA;
        next_cycle();
        a_in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_data_out !== 16'h0AAA || a_out_last !== 1'b0) begin
            n_err++;
            $display("FAIL rst_new_slice0: vld=%b dout=%h last=%b, want 1 0aaa 0",
                     a_out_valid, a_data_out, a_out_last);
        end
        repeat (3) next_cycle();
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_data_out !== 16'h0DDD || a_out_last !== 1'b1) begin
            n_err++;
            $display("FAIL rst_new_slice3: vld=%b dout=%h last=%b, want 1 0ddd 1",
                     a_out_valid, a_data_out, a_out_last);
        end
        next_cycle();
        a_out_ready = 1'b0;
    endtask

    task automatic test_num_shifts_one();
        b_in_valid  = 1'b1;
        b_data_in   = 16'h0001;
        b_out_ready = 1'b1;
        #1;
        n_cmp++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ns1_start: rdy=%b vld=%b, want 1 0", b_in_ready, b_out_valid);
        end
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            if (i < 16) begin
                b_data_in = 16'(i + 1);
            end else begin
                b_in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (b_out_valid !== 1'b1 || b_data_out !== 16'(i) ||
                b_out_last !== 1'b1 || b_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL ns1_out%0d: vld=%b dout=%h last=%b rdy=%b, want 1 %h 1 1",
                         i, b_out_valid, b_data_out, b_out_last, b_in_ready, 16'(i));
            end
        end
        next_cycle();
        #1;
        n_cmp++;
        if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ns1_idle: vld=%b busy=%b, want 0 0", b_out_valid, b_busy);
        end
    endtask

    initial begin
        test_reset();
        next_cycle();
        test_single_word();
        next_cycle();
        test_back_to_back();
        next_cycle();
        test_backpressure();
        next_cycle();
        test_reset_mid_drain();
        next_cycle();
        test_num_shifts_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_piso_stream_ctrl
`default_nettype wire

// File: doc/piso_stream_ctrl.md
# piso_stream_ctrl

Handshaked sequencer for the wide-to-narrow serializer. Accepts one DATA_IN_WIDTH word on a valid/ready input stream, loads it into an internal `piso`, and emits NUM_SHIFTS = DATA_IN_WIDTH/DATA_OUT_WIDTH narrow words, least-significant first, on a valid/ready output stream. Sits between DNN buffer read ports and narrower PE/bus consumers. Sustains one output word per cycle, including across input-word boundaries.

## Interface
- DATA_IN_WIDTH, 64, wide input word width; must be an integer multiple of DATA_OUT_WIDTH.
- DATA_OUT_WIDTH, 16, narrow output word width.
- CLK  input  1  sole clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  DATA_IN is valid.
- IN_READY  output  1  block accepts DATA_IN this cycle.
- DATA_IN  input  DATA_IN_WIDTH  wide word.
- OUT_VALID  output  1  DATA_OUT holds a valid narrow word.
- OUT_READY  input  1  consumer takes DATA_OUT this cycle.
- DATA_OUT  output  DATA_OUT_WIDTH  current narrow word (`piso` low slice).
- OUT_LAST  output  1  DATA_OUT is the final slice of the current wide word.
- BUSY  output  1  a wide word is loaded and not yet fully drained.

## Operation
- States: IDLE (nothing loaded), DRAIN (slices pending). Counter `idx` (width max(1, clog2(NUM_SHIFTS))) holds the index of the slice currently on DATA_OUT.
- in_fire = IN_VALID & IN_READY. out_fire = OUT_VALID & OUT_READY.
- IN_READY = (state==IDLE) | (OUT_READY & idx==NUM_SHIFTS-1 & state==DRAIN). The combinational path OUT_READY->IN_READY is intentional and enables back-to-back words.
- OUT_VALID = (state==DRAIN). OUT_LAST = OUT_VALID & (idx==NUM_SHIFTS-1). BUSY = (state==DRAIN).
- `piso` LOAD = in_fire. SHIFT = out_fire & ~OUT_LAST. The `piso` gives LOAD priority over SHIFT, so a load coincident with the last out_fire replaces the data and no shift occurs.
- IDLE: in_fire -> DRAIN, idx<=0.
- DRAIN, out_fire and not last: idx<=idx+1, stay in DRAIN.
- DRAIN, out_fire and last: with in_fire -> stay in DRAIN, idx<=0. Without in_fire -> IDLE.
- DRAIN, no out_fire: hold state, idx, and data. DATA_OUT stays stable while OUT_VALID & ~OUT_READY.
- NUM_SHIFTS==1: every slice is last; the block degenerates to a one-entry pipeline register with full throughput.
- DATA_OUT is don't-care while OUT_VALID=0. Its value after reset is 0.

## Timing
- Reset: state=IDLE, idx=0, serial register=0. Therefore IN_READY=1, OUT_VALID=0, OUT_LAST=0, BUSY=0, DATA_OUT=0.
- RESET mid-drain discards remaining slices with no output. RESET has priority over any concurrent in_fire or out_fire.
- Latency: in_fire at cycle t -> slice 0 valid at t+1. With OUT_READY held high, slice k is valid at t+1+k.
- Throughput: with IN_VALID and OUT_READY held high, one output word per cycle with no gap between wide words. IN_READY pulses once every NUM_SHIFTS cycles.
- IN_VALID while DRAIN and not on the last out_fire: IN_READY=0 and the word is not taken.

## Structure
- Shared package `piso_ctrl_pkg`: state encoding (IDLE=1'b0, DRAIN=1'b1) and a clog2 function for the counter width.
- Instantiate the existing `piso` sub-module with the same two width parameters. The controller must not duplicate its shift register.
- Elaboration-time check: DATA_IN_WIDTH % DATA_OUT_WIDTH == 0.

## Test plan
- Reset then idle: hold RESET 2 cycles -> IN_READY=1, OUT_VALID=0, DATA_OUT=0, BUSY=0.
- Single word, 64->16, OUT_READY=1: DATA_IN=0x4444_3333_2222_1111 accepted at t -> DATA_OUT 0x1111, 0x2222, 0x3333, 0x4444 on t+1..t+4. OUT_LAST only at t+4. IDLE at t+5.
- Back-to-back: two words 0xDDDD_CCCC_BBBB_AAAA and 0x8888_7777_6666_5555 with IN_VALID high -> 8 consecutive valid outputs, no bubble. Second IN_READY coincides with the 0xDDDD output.
- Backpressure: OUT_READY low for 3 cycles on slice 0x2222 -> DATA_OUT holds 0x2222, idx frozen, IN_READY=0. Drain resumes in order when OUT_READY returns.
- Reset mid-drain: RESET asserted after 0x2222 is consumed -> next cycle OUT_VALID=0, DATA_OUT=0. A new word afterwards drains from slice 0.
- NUM_SHIFTS=1 (DATA_IN_WIDTH=DATA_OUT_WIDTH=16): stream 0x0001..0x0010 -> every output has OUT_LAST=1. Full rate with OUT_READY=1.
